// File: rtl/maxpool_stream.sv
// -----------------------------------------------------------------------------
// maxpool_stream
//
// Streaming pooling stage for the CNN datapath. Every 2^win_log2 consecutive
// accepted input beats are reduced to a single output beat, independently on
// each of `channels` parallel lanes. The reduction is either max or average
// (floor rounding), on unsigned or two's complement lane data.
//
// Ports:
//   clk_in     - clock, all state updates on the rising edge
//   rst        - asynchronous, active-high reset
//   mode       - 0 = max, 1 = average; latched on the first beat of a window
//   clear      - synchronous abort of the partial window (pending output kept)
//   in_valid   - data_in carries a beat
//   in_ready   - block accepts a beat this cycle
//   data_in    - packed input lanes, lane k at [k*bits +: bits]
//   out_valid  - data_out holds a finished window result
//   out_ready  - downstream accepts data_out
//   data_out   - packed result lanes, registered
// -----------------------------------------------------------------------------
module maxpool_stream #(
    parameter int bits        = 8,
    parameter int channels    = 4,
    parameter int win_log2    = 2,
    parameter int signed_data = 0
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic                       mode,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [channels*bits-1:0]   data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [channels*bits-1:0]   data_out
);

    // Accumulator is wide enough to hold the sum of a whole window.
    localparam int AW = bits + win_log2;
    // The counter keeps at least one bit so win_log2=0 still elaborates;
    // in that case it simply stays at zero.
    localparam int CW = (win_log2 > 0) ? win_log2 : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << win_log2) - 1);

    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     mode_q, mode_d;
    logic                     out_valid_q, out_valid_d;
    logic [channels*bits-1:0] data_out_q, data_out_d;

    logic                     first_beat;
    logic                     last_beat;
    logic                     mode_eff;
    logic                     accept;
    logic                     take;
    logic [channels*bits-1:0] lane_res;

    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == LAST);

    // The first beat of a window uses the live mode input; later beats use
    // the copy latched at that first beat, so mid-window changes are ignored.
    assign mode_eff = first_beat ? mode : mode_q;

    // Only the completing beat can stall: it needs the output register, and
    // that register is busy while a result waits for downstream.
    assign in_ready = ~(last_beat & out_valid_q & ~out_ready);
    assign accept   = in_valid & in_ready;
    // A beat accepted together with clear is dropped along with the window.
    assign take     = accept & ~clear;

    // -------------------------------------------------------------------------
    // Per-lane accumulate / reduce
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < channels; gi++) begin : g_lane
            logic [bits-1:0] sample;
            logic [AW-1:0]   sample_ext;
            logic [AW-1:0]   acc_q, acc_d;
            logic [AW-1:0]   acc_comb;
            logic [bits-1:0] shifted;
            logic [bits-1:0] res;
            logic            larger;

            assign sample = data_in[gi*bits +: bits];

            always_comb begin
                // Samples are widened to accumulator width once; max results
                // are then compared at that width too, so both paths agree on
                // signedness.
                if (signed_data != 0) begin
                    sample_ext = AW'($signed(sample));
                    larger     = $signed(sample_ext) > $signed(acc_q);
                end else begin
                    sample_ext = AW'(sample);
                    larger     = sample_ext > acc_q;
                end

                // First beat loads directly, so an all-negative window never
                // sees a spurious zero.
                if (first_beat) begin
                    acc_comb = sample_ext;
                end else if (mode_eff) begin
                    acc_comb = acc_q + sample_ext;
                end else if (larger) begin
                    acc_comb = sample_ext;
                end else begin
                    acc_comb = acc_q;
                end

                // Division by the window length; arithmetic shift gives floor
                // rounding for negative sums.
                if (signed_data != 0) begin
                    shifted = bits'($signed(acc_comb) >>> win_log2);
                end else begin
                    shifted = bits'(acc_comb >> win_log2);
                end

                res   = mode_eff ? shifted : acc_comb[bits-1:0];
                acc_d = take ? acc_comb : acc_q;
            end

            always_ff @(posedge clk_in or posedge rst) begin
                if (rst) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            assign lane_res[gi*bits +: bits] = res;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Window counter, mode latch and output register
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;

        // Downstream consumed the current result.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            if (first_beat) begin
                mode_d = mode;
            end
            if (last_beat) begin
                // Completion overrides a same-cycle transfer: the new result
                // replaces the one just consumed, keeping full throughput.
                cnt_d       = '0;
                out_valid_d = 1'b1;
                data_out_d  = lane_res;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool_stream
//
// Drives an unsigned and a signed instance of maxpool_stream (bits=8,
// channels=4, window of 4 beats) from the same stimulus. A window-level
// reference model (queue of beats, results computed with integer arithmetic)
// predicts in_ready, out_valid and data_out every cycle. Hand-computed vectors
// and short sequences cover backpressure, clear and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_maxpool_stream;

    localparam int W = 4;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        mode;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] data_in;

    logic        in_ready_u, out_valid_u;
    logic [31:0] data_out_u;
    logic        in_ready_s, out_valid_s;
    logic [31:0] data_out_s;

    always #5 clk_in = ~clk_in;

    maxpool_stream #(.bits(8), .channels(4), .win_log2(2), .signed_data(0)) dut_u (
        .clk_in    (clk_in),
        .rst       (rst),
        .mode      (mode),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready_u),
        .data_in   (data_in),
        .out_valid (out_valid_u),
        .out_ready (out_ready),
        .data_out  (data_out_u)
    );

    maxpool_stream #(.bits(8), .channels(4), .win_log2(2), .signed_data(1)) dut_s (
        .clk_in    (clk_in),
        .rst       (rst),
        .mode      (mode),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .data_in   (data_in),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .data_out  (data_out_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a window is just the list of beats seen so far.
    // ------------------------------------------------------------------
    logic [31:0] mq[$];
    bit          mode_m;
    bit          pend_v;
    logic [31:0] pend_u, pend_s;
    bit          last_acc;

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [31:0] pool(input logic [31:0] b[W], input bit md, input bit sgn);
        logic [31:0] r;
        logic [7:0]  x;
        byte         sb;
        int          v, acc;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int i = 0; i < W; i++) begin
                x  = b[i][k*8 +: 8];
                sb = x;
                v  = sgn ? int'(sb) : int'(x);
                if (i == 0)       acc = v;
                else if (md)      acc = acc + v;
                else if (v > acc) acc = v;
            end
            if (md) acc = floor_div(acc, W);
            r[k*8 +: 8] = acc[7:0];
        end
        return r;
    endfunction

    function automatic bit model_ready(input bit ordy);
        return !(mq.size() == W-1 && pend_v && !ordy);
    endfunction

    function automatic void model_reset();
        mq.delete();
        mode_m = 1'b0;
        pend_v = 1'b0;
        pend_u = '0;
        pend_s = '0;
    endfunction

    task automatic model_step(input bit v, input bit rdy, input logic [31:0] d,
                              input bit md, input bit clr, input bit ordy);
        logic [31:0] win [W];
        bit          done;
        done = 1'b0;
        if (pend_v && ordy)
            $display("xfer t=%0t unsigned=%h signed=%h", $time, pend_u, pend_s);
        if (clr) begin
            mq.delete();
        end else if (v && rdy) begin
            if (mq.size() == 0) mode_m = md;
            mq.push_back(d);
            if (mq.size() == W) begin
                for (int i = 0; i < W; i++) win[i] = mq[i];
                pend_u = pool(win, mode_m, 1'b0);
                pend_s = pool(win, mode_m, 1'b1);
                done   = 1'b1;
                mq.delete();
            end
        end
        if (done)                pend_v = 1'b1;
        else if (pend_v && ordy) pend_v = 1'b0;
    endtask

    // One clock cycle: apply inputs, check in_ready before the edge, advance
    // the model at the edge, check registered outputs just after it.
    task automatic cycle(input bit v, input logic [31:0] d, input bit md,
                         input bit clr, input bit ordy);
        bit rdy;
        in_valid  = v;
        data_in   = d;
        mode      = md;
        clear     = clr;
        out_ready = ordy;
        #2;
        rdy = model_ready(ordy);
        chk("in_ready_u", {31'b0, in_ready_u}, {31'b0, rdy});
        chk("in_ready_s", {31'b0, in_ready_s}, {31'b0, rdy});
        last_acc = v && rdy && !clr;
        @(posedge clk_in);
        model_step(v, rdy, d, md, clr, ordy);
        #1;
        chk("out_valid_u", {31'b0, out_valid_u}, {31'b0, pend_v});
        chk("out_valid_s", {31'b0, out_valid_s}, {31'b0, pend_v});
        chk("data_out_u", data_out_u, pend_u);
        chk("data_out_s", data_out_s, pend_s);
    endtask

    // ------------------------------------------------------------------
    // Hand-computed window vectors (lane3..lane0 packed per beat)
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] beat [W];
        bit          md;
        logic [31:0] exp_u;
        logic [31:0] exp_s;
    } vec_t;

    vec_t vec [4];

    task automatic set_vec(input int idx, input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3, input bit md,
                           input logic [31:0] eu, input logic [31:0] es);
        vec[idx].beat[0] = b0;
        vec[idx].beat[1] = b1;
        vec[idx].beat[2] = b2;
        vec[idx].beat[3] = b3;
        vec[idx].md      = md;
        vec[idx].exp_u   = eu;
        vec[idx].exp_s   = es;
    endtask

    task automatic chk_out(input string name, input logic [31:0] eu, input logic [31:0] es);
        chk({name, "_valid_u"}, {31'b0, out_valid_u}, 32'd1);
        chk({name, "_valid_s"}, {31'b0, out_valid_s}, 32'd1);
        chk({name, "_data_u"}, data_out_u, eu);
        chk({name, "_data_s"}, data_out_s, es);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // lane0 3,9,2,7 max; lane2 mixes 0xFF/0x80 to split signed vs unsigned
        set_vec(0, 32'h05FF0A03, 32'h05001409, 32'h05801E02, 32'h05012807, 1'b0,
                32'h05FF2809, 32'h05012809);
        // lane0 -5,-2,-9,-3 signed max -> 0xFE
        set_vec(1, 32'h807F01FB, 32'h808002FE, 32'h800003F7, 32'h811004FD, 1'b0,
                32'h818004FE, 32'h817F04FE);
        // lane0 -3,-4,-4,-4 avg -> 0xFC; lane1 255,255,255,254 -> 254 unsigned
        set_vec(2, 32'h8001FFFD, 32'h8002FFFC, 32'h8003FFFC, 32'h8004FEFC, 1'b1,
                32'h8002FEFC, 32'h8002FEFC);
        // lane3 1,-1,1,-1: unsigned avg 128, signed avg 0
        set_vec(3, 32'h01811000, 32'hFF812000, 32'h01813000, 32'hFF814003, 1'b1,
                32'h80812800, 32'h00812800);

        rst = 1'b1; mode = 1'b0; clear = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; data_in = '0;
        model_reset();
        #12;
        chk("rst_valid_u", {31'b0, out_valid_u}, 32'd0);
        chk("rst_valid_s", {31'b0, out_valid_s}, 32'd0);
        chk("rst_data_u", data_out_u, 32'd0);
        chk("rst_data_s", data_out_s, 32'd0);
        chk("rst_ready_u", {31'b0, in_ready_u}, 32'd1);
        rst = 1'b0;
        @(posedge clk_in); #1;

        // Table vectors back to back; mode flipped after the first beat must
        // have no effect.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < W; i++)
                cycle(1'b1, vec[t].beat[i], (i == 0) ? vec[t].md : ~vec[t].md, 1'b0, 1'b1);
            chk_out($sformatf("vec%0d", t), vec[t].exp_u, vec[t].exp_s);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("vec_drain_valid", {31'b0, out_valid_u}, 32'd0);

        // Backpressure across two windows.
        for (int i = 0; i < W; i++)
            cycle(1'b1, vec[1].beat[i], 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W-1; i++)
            cycle(1'b1, vec[3].beat[i], (i == 0), 1'b0, 1'b0);
        repeat (2) begin
            cycle(1'b1, vec[3].beat[3], 1'b0, 1'b0, 1'b0);
            chk("bp_stall_ready", {31'b0, in_ready_u}, 32'd0);
            chk_out("bp_hold", vec[1].exp_u, vec[1].exp_s);
        end
        cycle(1'b1, vec[3].beat[3], 1'b0, 1'b0, 1'b1);
        chk_out("bp_second", vec[3].exp_u, vec[3].exp_s);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("bp_drain_valid", {31'b0, out_valid_u}, 32'd0);

        // Clear with a pending output.
        for (int i = 0; i < W; i++)
            cycle(1'b1, vec[0].beat[i], 1'b0, 1'b0, 1'b0);
        cycle(1'b1, vec[1].beat[0], 1'b0, 1'b0, 1'b0);
        cycle(1'b1, vec[1].beat[1], 1'b1, 1'b0, 1'b0);
        cycle(1'b1, vec[1].beat[2], 1'b1, 1'b1, 1'b0);
        chk_out("clr_pending", vec[0].exp_u, vec[0].exp_s);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("clr_delivered", {31'b0, out_valid_u}, 32'd0);
        for (int i = 0; i < W; i++)
            cycle(1'b1, vec[2].beat[i], (i == 0), 1'b0, 1'b1);
        chk_out("clr_fresh", vec[2].exp_u, vec[2].exp_s);

        // Asynchronous reset mid-window with a pending output.
        for (int i = 0; i < W; i++)
            cycle(1'b1, vec[0].beat[i], 1'b0, 1'b0, 1'b0);
        cycle(1'b1, vec[1].beat[0], 1'b0, 1'b0, 1'b0);
        cycle(1'b1, vec[1].beat[1], 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid_u", {31'b0, out_valid_u}, 32'd0);
        chk("arst_valid_s", {31'b0, out_valid_s}, 32'd0);
        chk("arst_data_u", data_out_u, 32'd0);
        chk("arst_data_s", data_out_s, 32'd0);
        chk("arst_ready_u", {31'b0, in_ready_u}, 32'd1);
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk_in); #1;
        for (int i = 0; i < W; i++)
            cycle(1'b1, vec[3].beat[i], (i == 0), 1'b0, 1'b1);
        chk_out("arst_after", vec[3].exp_u, vec[3].exp_s);

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            cycle($urandom_range(0, 9) < 7, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
Parametrised pooling stage for the CNN datapath, the next generation of the single-channel max-pool unit. It reduces each group of 2^win_log2 consecutive input beats to one output beat, independently on `channels` parallel lanes. Each window is reduced by either max or average, on signed or unsigned data. Full valid/ready handshake on input and output, so it sits between a conv/activation stage and a line buffer with backpressure.

Parameters:
bits, 8, data width per channel lane
channels, 4, number of parallel lanes packed in data_in/data_out (lane k at bits [k*bits +: bits])
win_log2, 2, log2 of window length; window = 2^win_log2 beats; legal 0..4
signed_data, 0, 1 = lanes are two's complement (signed compare, arithmetic shift); 0 = unsigned

Ports:
clk_in  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
mode  input  1  0 = max, 1 = average; sampled on the first accepted beat of each window
clear  input  1  synchronous abort of the partial window
in_valid  input  1  data_in valid
in_ready  output  1  block accepts a beat this cycle
data_in  input  channels*bits  packed input lanes
out_valid  output  1  data_out holds a finished window result
out_ready  input  1  downstream accepts data_out
data_out  output  channels*bits  packed result lanes, registered

Behaviour:
- Reset (async, rst=1): cnt=0, all lane accumulators=0, mode_q=0, out_valid=0, data_out=0. in_ready reads 1 while out_valid=0.
- Accept: a beat is accepted when in_valid & in_ready at the rising edge.
- Window counter: cnt runs 0..2^win_log2-1 and wraps to 0 after the last beat.
- First beat (cnt=0):
  - each lane accumulator loads the sample directly (no compare against 0, so all-negative windows are correct);
  - mode is latched into mode_q; mode changes mid-window are ignored.
- Middle beats:
  - max: acc = larger(acc, sample), compared signed or unsigned per signed_data.
  - avg: acc = acc + sample, sign-extended when signed_data=1. Accumulator width is bits+win_log2, so it never overflows.
- Last beat (cnt = 2^win_log2-1), the completion edge:
  - combine the last sample as above;
  - data_out lane = max result, or (sum >> win_log2) with arithmetic shift when signed (floor rounding), truncated to bits;
  - out_valid <= 1; cnt <= 0.
  - Latency: result visible the cycle after the completing beat.
- in_ready = 1, except when cnt is at the last beat and out_valid=1 and out_ready=0. Only the completing beat stalls; middle beats always flow.
- Output handshake:
  - out_valid and data_out stay stable until out_valid & out_ready.
  - Transfer with no completion in the same cycle: out_valid <= 0.
  - Transfer and completion in the same cycle: out_valid stays 1 and data_out takes the new result (full throughput, one window per 2^win_log2 cycles).
- clear=1: cnt <= 0 and the partial window is discarded. A beat accepted in the same cycle is also discarded. A pending output (out_valid=1) is kept and is still delivered.
- win_log2=0: every beat is its own window; a registered pass-through with 1-cycle latency, mode has no effect.
- Async rst mid-window or with a pending output: everything is dropped immediately and the block restarts at cnt=0.

Test Plan:
- Unsigned max, channels=4, win_log2=2, out_ready=1: lane0 beats 3,9,2,7 -> one out_valid pulse one cycle after beat 4, lane0=9; other lanes checked the same way.
- Signed max, signed_data=1, bits=8: -5,-2,-9,-3 -> -2 (0xFE); checks the first-beat load rather than a compare against 0.
- Average, signed_data=1: -3,-4,-4,-4 (sum -15) -> -4 (0xFC, floor). Unsigned 255,255,255,254 -> 254.
- Backpressure: out_ready=0 across two full windows -> in_ready drops only on the 4th beat of window 2; first result held stable; out_ready=1 -> result 1 transfers, in_ready rises, result 2 appears the next cycle; no beats lost or duplicated.
- mode toggled on the 2nd beat, and clear asserted on the 3rd beat with a pending output -> pending output still delivered; the next 4 beats form a fresh window using mode sampled at its first beat.
- rst pulsed mid-window (cnt=2) and asynchronously between clock edges -> out_valid=0, data_out=0 immediately; the next 4 beats produce a correct window.
